// File: rtl/gan_batch_sequencer.sv
// ============================================================================
// Module   : gan_batch_sequencer
// Brief    : Batch controller sequencing generator/discriminator per sample.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gan_batch_sequencer #(
    parameter int DATA_WIDTH = 16,
    parameter int LATENT_DIM = 2,
    parameter int IMAGE_SIZE = 9,
    parameter int MAX_BATCH  = 16,
    parameter int BW         = $clog2(MAX_BATCH + 1),
    parameter int ACC_WIDTH  = 24,
    parameter int TIMEOUT    = 1023
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [1:0]                       i_cfg_mode,
    input  logic [BW-1:0]                    i_cfg_batch,
    input  logic [DATA_WIDTH-1:0]            i_cfg_threshold,
    input  logic                             i_start,
    input  logic                             i_abort,
    output logic                             o_busy,
    output logic                             o_done,
    output logic                             o_error,
    input  logic                             i_s_valid,
    output logic                             o_s_ready,
    input  logic [LATENT_DIM*DATA_WIDTH-1:0] i_s_latent,
    input  logic [IMAGE_SIZE*DATA_WIDTH-1:0] i_s_image,
    output logic                             o_gen_start,
    output logic [LATENT_DIM*DATA_WIDTH-1:0] o_gen_latent,
    input  logic                             i_gen_done,
    input  logic [IMAGE_SIZE*DATA_WIDTH-1:0] i_gen_image,
    output logic                             o_disc_start,
    output logic [IMAGE_SIZE*DATA_WIDTH-1:0] o_disc_image,
    input  logic                             i_disc_done,
    input  logic [DATA_WIDTH-1:0]            i_disc_score,
    output logic                             o_m_valid,
    input  logic                             i_m_ready,
    output logic [IMAGE_SIZE*DATA_WIDTH-1:0] o_m_image,
    output logic [DATA_WIDTH-1:0]            o_m_score,
    output logic [BW-1:0]                    o_m_index,
    output logic                             o_m_last,
    output logic [ACC_WIDTH-1:0]             o_sum_score,
    output logic [BW-1:0]                    o_real_count
);

    localparam int              c_WDW     = $clog2(TIMEOUT + 1);
    localparam logic [c_WDW-1:0] c_WD_LAST = c_WDW'(TIMEOUT - 1);
    localparam logic [1:0]      c_MODE_GEN  = 2'b00;
    localparam logic [1:0]      c_MODE_DISC = 2'b01;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_GEN    = 3'd2,
        S_DISC   = 3'd3,
        S_EMIT   = 3'd4,
        S_FINISH = 3'd5
    } state_t;

    state_t                            r_state;
    logic [1:0]                        r_mode;
    logic [BW-1:0]                     r_batch;
    logic [DATA_WIDTH-1:0]             r_thresh;
    logic [BW-1:0]                     r_index;
    logic [c_WDW-1:0]                  r_wdog;
    logic                              r_done;
    logic                              r_error;
    logic                              r_gen_start;
    logic                              r_disc_start;
    logic [LATENT_DIM*DATA_WIDTH-1:0]  r_gen_latent;
    logic [IMAGE_SIZE*DATA_WIDTH-1:0]  r_disc_image;
    logic [IMAGE_SIZE*DATA_WIDTH-1:0]  r_m_image;
    logic [DATA_WIDTH-1:0]             r_m_score;
    logic [ACC_WIDTH-1:0]              r_sum;
    logic [BW-1:0]                     r_real;

    logic                              w_cfg_bad;
    logic                              w_last;
    logic                              w_real;
    logic [ACC_WIDTH:0]                w_sum_ext;
    logic [ACC_WIDTH-1:0]              w_sum_sat;

    assign w_cfg_bad = (i_cfg_batch == '0) || (i_cfg_batch > BW'(MAX_BATCH))
                       || (i_cfg_mode == 2'b11);
    assign w_last    = (r_index == r_batch - BW'(1));
    assign w_real    = $signed(i_disc_score) > $signed(r_thresh);

    // One guard bit: top two bits disagreeing means the signed sum overflowed.
    assign w_sum_ext = {r_sum[ACC_WIDTH-1], r_sum}
                     + {{(ACC_WIDTH + 1 - DATA_WIDTH){i_disc_score[DATA_WIDTH-1]}}, i_disc_score};
    assign w_sum_sat = (w_sum_ext[ACC_WIDTH] == w_sum_ext[ACC_WIDTH-1]) ? w_sum_ext[ACC_WIDTH-1:0]
                     : (w_sum_ext[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                             : {1'b0, {(ACC_WIDTH-1){1'b1}}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_mode       <= '0;
            r_batch      <= '0;
            r_thresh     <= '0;
            r_index      <= '0;
            r_wdog       <= '0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_gen_start  <= 1'b0;
            r_disc_start <= 1'b0;
            r_gen_latent <= '0;
            r_disc_image <= '0;
            r_m_image    <= '0;
            r_m_score    <= '0;
            r_sum        <= '0;
            r_real       <= '0;
        end else begin
            r_gen_start  <= 1'b0;
            r_disc_start <= 1'b0;
            r_done       <= 1'b0;
            if (r_state != S_IDLE && i_abort) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (i_start) begin
                            r_mode   <= i_cfg_mode;
                            r_batch  <= i_cfg_batch;
                            r_thresh <= i_cfg_threshold;
                            r_sum    <= '0;
                            r_real   <= '0;
                            r_index  <= '0;
                            r_error  <= w_cfg_bad;
                            r_state  <= w_cfg_bad ? S_FINISH : S_FETCH;
                        end
                    end
                    S_FETCH: begin
                        if (i_s_valid) begin
                            r_gen_latent <= i_s_latent;
                            r_disc_image <= i_s_image;
                            r_wdog       <= '0;
                            if (r_mode == c_MODE_DISC) begin
                                r_disc_start <= 1'b1;
                                r_state      <= S_DISC;
                            end else begin
                                r_gen_start <= 1'b1;
                                r_state     <= S_GEN;
                            end
                        end
                    end
                    S_GEN: begin
                        if (i_gen_done) begin
                            r_m_image    <= i_gen_image;
                            r_disc_image <= i_gen_image;
                            r_wdog       <= '0;
                            if (r_mode == c_MODE_GEN) begin
                                r_m_score <= '0;
                                r_state   <= S_EMIT;
                            end else begin
                                r_disc_start <= 1'b1;
                                r_state      <= S_DISC;
                            end
                        end else if (r_wdog == c_WD_LAST) begin
                            r_error <= 1'b1;
                            r_state <= S_FINISH;
                        end else begin
                            r_wdog <= r_wdog + c_WDW'(1);
                        end
                    end
                    S_DISC: begin
                        if (i_disc_done) begin
                            r_m_score <= i_disc_score;
                            r_m_image <= r_disc_image;
                            r_sum     <= w_sum_sat;
                            if (w_real) begin
                                r_real <= r_real + BW'(1);
                            end
                            r_state <= S_EMIT;
                        end else if (r_wdog == c_WD_LAST) begin
                            r_error <= 1'b1;
                            r_state <= S_FINISH;
                        end else begin
                            r_wdog <= r_wdog + c_WDW'(1);
                        end
                    end
                    S_EMIT: begin
                        if (i_m_ready) begin
                            r_index <= r_index + BW'(1);
                            r_state <= w_last ? S_FINISH : S_FETCH;
                        end
                    end
                    S_FINISH: begin
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign o_busy       = (r_state != S_IDLE);
    assign o_done       = r_done;
    assign o_error      = r_error;
    assign o_s_ready    = (r_state == S_FETCH);
    assign o_gen_start  = r_gen_start;
    assign o_gen_latent = r_gen_latent;
    assign o_disc_start = r_disc_start;
    assign o_disc_image = r_disc_image;
    assign o_m_valid    = (r_state == S_EMIT);
    assign o_m_image    = r_m_image;
    assign o_m_score    = r_m_score;
    assign o_m_index    = r_index;
    assign o_m_last     = (r_state == S_EMIT) && w_last;
    assign o_sum_score  = r_sum;
    assign o_real_count = r_real;

endmodule

`default_nettype wire
